// File: rtl/cmp_dr_sequencer.sv
// Clocked sequencer for a dual-rail 4-phase comparator island: encode, go, capture, return-to-zero, respond.
// Optional macro CMP_SEQ_TIMEOUT_EN adds a per-phase watchdog with a RECOVER state.
module cmp_dr_sequencer #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE         = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_lt,
  output logic             out_err,
  output logic [WIDTH-1:0] cmp_a_1,
  output logic [WIDTH-1:0] cmp_a_0,
  output logic [WIDTH-1:0] cmp_b_1,
  output logic [WIDTH-1:0] cmp_b_0,
  output logic             cmp_go,
  output logic             cmp_reset,
  input  logic             cmp_done,
  input  logic             cmp_gt_1,
  input  logic             cmp_gt_0,
  input  logic             cmp_eq_1,
  input  logic             cmp_eq_0,
  input  logic             cmp_lt_1,
  input  logic             cmp_lt_0
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES + 2 > SETTLE) ? TIMEOUT_CYCLES + 2 : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
`ifdef CMP_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_RST  = CNT_W'(2);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_EVAL,
    S_CAPTURE,
    S_RTZ,
    S_RESP
`ifdef CMP_SEQ_TIMEOUT_EN
    , S_RECOVER,
    S_HALT
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] done_sync;
  logic [1:0]       rst_sh;
  logic             done_s;
  logic [WIDTH-1:0] a1_nxt, a0_nxt, b1_nxt, b0_nxt;
  logic             go_nxt, gt_nxt, eq_nxt, lt_nxt, err_nxt;

  // Each pair must be a valid codeword and exactly one relation may be true.
  function automatic logic result_ok(input logic gt1, input logic gt0, input logic eq1,
                                     input logic eq0, input logic lt1, input logic lt0);
    logic       pairs_ok;
    logic [1:0] ones;
    pairs_ok = (gt1 ^ gt0) & (eq1 ^ eq0) & (lt1 ^ lt0);
    ones     = {1'b0, gt1} + {1'b0, eq1} + {1'b0, lt1};
    return pairs_ok && (ones == 2'd1);
  endfunction

  assign done_s = done_sync[SYNC_STAGES-1];

`ifdef CMP_SEQ_TIMEOUT_EN
  assign cmp_reset = ~rst_sh[1] | ((state == S_RECOVER) && (cnt < REC_RST)) | (state == S_HALT);
`else
  assign cmp_reset = ~rst_sh[1];
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a1_nxt    = cmp_a_1;
    a0_nxt    = cmp_a_0;
    b1_nxt    = cmp_b_1;
    b0_nxt    = cmp_b_0;
    go_nxt    = cmp_go;
    gt_nxt    = out_gt;
    eq_nxt    = out_eq;
    lt_nxt    = out_lt;
    err_nxt   = out_err;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst_sh[1];
        if (in_valid && rst_sh[1]) begin
          a1_nxt    = in_a;
          a0_nxt    = ~in_a;
          b1_nxt    = in_b;
          b0_nxt    = ~in_b;
          cnt_nxt   = '0;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          go_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_EVAL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_EVAL: begin
        if (done_s) begin
          state_nxt = S_CAPTURE;
`ifdef CMP_SEQ_TIMEOUT_EN
        end else if (cnt == WD_LAST) begin
          {a1_nxt, a0_nxt, b1_nxt, b0_nxt} = '0;
          go_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_RECOVER;
        end else begin
          cnt_nxt = cnt + 1'b1;
`endif
        end
      end
      S_CAPTURE: begin
        if (result_ok(cmp_gt_1, cmp_gt_0, cmp_eq_1, cmp_eq_0, cmp_lt_1, cmp_lt_0)) begin
          {gt_nxt, eq_nxt, lt_nxt, err_nxt} = {cmp_gt_1, cmp_eq_1, cmp_lt_1, 1'b0};
        end else begin
          {gt_nxt, eq_nxt, lt_nxt, err_nxt} = 4'b0001;
        end
        {a1_nxt, a0_nxt, b1_nxt, b0_nxt} = '0;
        go_nxt    = 1'b0;
        cnt_nxt   = '0;
        state_nxt = S_RTZ;
      end
      S_RTZ: begin
        if (!done_s) begin
          state_nxt = S_RESP;
`ifdef CMP_SEQ_TIMEOUT_EN
        end else if (cnt == WD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_RECOVER;
        end else begin
          cnt_nxt = cnt + 1'b1;
`endif
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          {gt_nxt, eq_nxt, lt_nxt, err_nxt} = 4'b0000;
          state_nxt = S_IDLE;
        end
      end
`ifdef CMP_SEQ_TIMEOUT_EN
      // First two cycles pulse cmp_reset, then the counter becomes the RTZ watchdog.
      S_RECOVER: begin
        if (cnt < REC_RST) begin
          cnt_nxt = cnt + 1'b1;
        end else if (!done_s) begin
          {gt_nxt, eq_nxt, lt_nxt, err_nxt} = 4'b0001;
          state_nxt = S_RESP;
        end else if (cnt == REC_LAST) begin
          state_nxt = S_HALT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      done_sync <= '0;
      rst_sh    <= '0;
      cmp_a_1   <= '0;
      cmp_a_0   <= '0;
      cmp_b_1   <= '0;
      cmp_b_0   <= '0;
      cmp_go    <= 1'b0;
      out_gt    <= 1'b0;
      out_eq    <= 1'b0;
      out_lt    <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      done_sync <= {done_sync[SYNC_STAGES-2:0], cmp_done};
      rst_sh    <= {rst_sh[0], 1'b1};
      cmp_a_1   <= a1_nxt;
      cmp_a_0   <= a0_nxt;
      cmp_b_1   <= b1_nxt;
      cmp_b_0   <= b0_nxt;
      cmp_go    <= go_nxt;
      out_gt    <= gt_nxt;
      out_eq    <= eq_nxt;
      out_lt    <= lt_nxt;
      out_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_dr_sequencer.sv
// Randomized bench for cmp_dr_sequencer with a behavioural dual-rail comparator and a plain-arithmetic result model.
// Mirrors CMP_SEQ_TIMEOUT_EN to choose the watchdog or no-watchdog expectation.
module tb_cmp_dr_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready;
  logic         out_gt, out_eq, out_lt, out_err;
  logic [W-1:0] cmp_a_1, cmp_a_0, cmp_b_1, cmp_b_0;
  logic         cmp_go, cmp_reset, cmp_done;
  logic         cmp_gt_1, cmp_gt_0, cmp_eq_1, cmp_eq_0, cmp_lt_1, cmp_lt_0;

  int errors = 0;
  int checks = 0;
  int model_mode = 0;  // 0 good, 1 gt pair 11, 2 eq&lt both true, 3 never completes
  int model_dly  = 5;

  cmp_dr_sequencer #(.WIDTH(W), .SYNC_STAGES(2), .SETTLE(1), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt), .out_err(out_err),
    .cmp_a_1(cmp_a_1), .cmp_a_0(cmp_a_0), .cmp_b_1(cmp_b_1), .cmp_b_0(cmp_b_0),
    .cmp_go(cmp_go), .cmp_reset(cmp_reset), .cmp_done(cmp_done),
    .cmp_gt_1(cmp_gt_1), .cmp_gt_0(cmp_gt_0), .cmp_eq_1(cmp_eq_1), .cmp_eq_0(cmp_eq_0),
    .cmp_lt_1(cmp_lt_1), .cmp_lt_0(cmp_lt_0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {gt,eq,lt,err} straight from the operand values.
  function automatic logic [3:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
    if (m != 0) return 4'b0001;
    return {a > b, a == b, a < b, 1'b0};
  endfunction

  // Behavioural self-timed comparator: decodes rails, completes model_dly cycles after go.
  initial begin
    int cnt;
    logic [W-1:0] ra, rb;
    cnt = 0;
    cmp_done = 1'b0;
    {cmp_gt_1, cmp_gt_0, cmp_eq_1, cmp_eq_0, cmp_lt_1, cmp_lt_0} = '0;
    forever begin
      @(negedge clk);
      if (reset || !cmp_go) begin
        cmp_done = 1'b0;
        {cmp_gt_1, cmp_gt_0, cmp_eq_1, cmp_eq_0, cmp_lt_1, cmp_lt_0} = '0;
        cnt = 0;
      end else if (!cmp_done) begin
        if (cnt >= model_dly && model_mode != 3) begin
          ra = cmp_a_1;
          rb = cmp_b_1;
          {cmp_gt_1, cmp_gt_0} = (ra > rb)  ? 2'b10 : 2'b01;
          {cmp_eq_1, cmp_eq_0} = (ra == rb) ? 2'b10 : 2'b01;
          {cmp_lt_1, cmp_lt_0} = (ra < rb)  ? 2'b10 : 2'b01;
          if (model_mode == 1) {cmp_gt_1, cmp_gt_0} = 2'b11;
          if (model_mode == 2) begin
            {cmp_gt_1, cmp_gt_0} = 2'b01;
            {cmp_eq_1, cmp_eq_0} = 2'b10;
            {cmp_lt_1, cmp_lt_0} = 2'b10;
          end
          cmp_done = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int m, input int dly,
                         input int hold, input logic bv, input logic [W-1:0] ba, input logic [W-1:0] bb);
    logic [3:0] exp;
    logic       seen_go, keep_ready;
    int         n, busy_bad;
    model_mode = m;
    model_dly  = dly;
    keep_ready = out_ready;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_ready", in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    check("busy_in_ready", in_ready, 0);
    in_valid = bv; in_a = ba; in_b = bb;
    exp = ref_cmp(a, b, m);
    seen_go = 1'b0; n = 0; busy_bad = 0;
    while (!out_valid && n < 300) begin
      if (cmp_go && !seen_go) begin
        seen_go = 1'b1;
        check("rails_at_go", {cmp_a_1, cmp_a_0, cmp_b_1, cmp_b_0}, {a, ~a, b, ~b});
      end
      if (in_ready) busy_bad++;
      @(negedge clk);
      n++;
    end
    check("resp_valid", out_valid, 1);
    check("go_seen", seen_go, 1);
    check("busy_ready_cycles", busy_bad, 0);
    check("spacer_at_resp", {cmp_a_1, cmp_a_0, cmp_b_1, cmp_b_0, cmp_go}, 0);
    check("flags", {out_gt, out_eq, out_lt, out_err}, exp);
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_flags", {out_gt, out_eq, out_lt, out_err}, exp);
        check("hold_in_ready", in_ready, 0);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("consumed", out_valid, 0);
    out_ready = keep_ready;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n, seen;
    logic [W-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cmp_reset", cmp_reset, 1);
    check("rst_rails_go", {cmp_a_1, cmp_a_0, cmp_b_1, cmp_b_0, cmp_go}, 0);
    check("rst_flags", {out_gt, out_eq, out_lt, out_err}, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rel1_cmp_reset", cmp_reset, 1);
    check("rel1_in_ready", in_ready, 0);
    @(negedge clk);
    check("rel2_cmp_reset", cmp_reset, 0);
    check("rel2_in_ready", in_ready, 1);

    // Directed: gt, eq then lt back-to-back with busy in_valid, protocol errors, held response.
    run_txn(4'h9, 4'h3, 0, 5, 0, 1'b0, 4'h0, 4'h0);
    out_ready = 1'b1;
    run_txn(4'hA, 4'hA, 0, 3, 0, 1'b1, 4'h2, 4'hC);
    run_txn(4'h2, 4'hC, 0, 3, 0, 1'b0, 4'h0, 4'h0);
    out_ready = 1'b0;
    run_txn(4'h7, 4'h1, 1, 2, 0, 1'b0, 4'h0, 4'h0);
    run_txn(4'h4, 4'h4, 2, 2, 0, 1'b0, 4'h0, 4'h0);
    run_txn(4'h3, 4'hE, 0, 4, 10, 1'b1, 4'hF, 4'h0);
    run_txn(4'hF, 4'hF, 0, 0, 0, 1'b0, 4'h0, 4'h0);
    run_txn(4'h0, 4'hF, 0, 0, 0, 1'b0, 4'h0, 4'h0);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = (i % 5 == 0) ? ra : W'($urandom_range(0, 15));
      run_txn(ra, rb, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0,
              int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1'($urandom),
              W'($urandom), W'($urandom));
    end

    // Reset in EVAL with go high; nothing from the aborted transaction may appear afterwards.
    model_mode = 0; model_dly = 30;
    in_a = 4'h5; in_b = 4'h6; in_valid = 1'b1;
    n = 0;
    while (!cmp_go && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    check("mid_go_high", cmp_go, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_async_outs", {cmp_a_1, cmp_a_0, cmp_b_1, cmp_b_0, cmp_go, in_ready, out_valid,
                             out_gt, out_eq, out_lt, out_err}, 0);
    check("mid_async_cmp_reset", cmp_reset, 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rel1_cmp_reset", cmp_reset, 1);
    @(negedge clk);
    check("mid_rel2_cmp_reset", cmp_reset, 0);
    seen = 0;
    out_ready = 1'b1;
    repeat (40) begin @(negedge clk); if (out_valid || cmp_go) seen++; end
    check("no_stale_resp", seen, 0);
    out_ready = 1'b0;

    // Comparator that never completes.
    model_mode = 3;
    in_a = 4'h8; in_b = 4'h1; in_valid = 1'b1;
    n = 0;
    while (!cmp_go && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    check("to_go_high", cmp_go, 1);
`ifdef CMP_SEQ_TIMEOUT_EN
    n = 0;
    while (!cmp_reset && n < 200) begin @(negedge clk); n++; end
    check("to_expiry_cycles", n, 64);
    check("to_spacer", {cmp_a_1, cmp_a_0, cmp_b_1, cmp_b_0, cmp_go}, 0);
    @(negedge clk);
    check("to_cmp_reset_2nd", cmp_reset, 1);
    @(negedge clk);
    check("to_cmp_reset_drop", cmp_reset, 0);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check("to_resp_valid", out_valid, 1);
    check("to_resp_flags", {out_gt, out_eq, out_lt, out_err}, 4'b0001);
    out_ready = 1'b1;
    @(negedge clk);
    check("to_consumed", out_valid, 0);
    out_ready = 1'b0;
`else
    seen = 0;
    out_ready = 1'b1;
    repeat (1000) begin @(negedge clk); if (out_valid) seen++; end
    check("no_timeout_resp", seen, 0);
    check("no_timeout_go_held", cmp_go, 1);
    out_ready = 1'b0;
`endif
    model_mode = 0;
    pulse_reset();
    run_txn(4'hB, 4'hC, 0, 2, 0, 1'b0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
